// File: rtl/vga_pkg.sv
// Shared VGA raster constants: 640x480@60 timing, totals, sync polarity and coordinate width.
package vga_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned MAX_TOTAL = 1 << COORD_W;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  localparam int unsigned H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int unsigned V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam bit SYNC_ACTIVE_LOW = 1'b0;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } raster_state_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with active/sync region decode.
// cnt, active and sync describe the count that takes effect on the current edge.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FP     = 16,
  parameter int unsigned SYNC   = 96,
  parameter int unsigned BP     = 48
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               step,
  input  logic               clear,
  output logic [COORD_W-1:0] cnt,
  output logic               wrap,
  output logic               active,
  output logic               sync
);

  localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP;
  localparam coord_t      LAST  = coord_t'(TOTAL - 1);

  if (TOTAL > MAX_TOTAL) begin : g_total_check
    $error("vga_axis_counter: axis total exceeds counter range");
  end

  coord_t cnt_q;

  assign wrap = step && (cnt_q == LAST);

  always_comb begin
    cnt = cnt_q;
    if (clear)
      cnt = '0;
    else if (step)
      cnt = wrap ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt;
  end

  assign active = 32'(cnt) < ACTIVE;
  assign sync   = (32'(cnt) >= ACTIVE + FP) && (32'(cnt) < ACTIVE + FP + SYNC);

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster sequencer: pixel clock-enable from clk_50, H/V counters and
// registered sync, display-enable, coordinate and start-pulse outputs.
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter bit          SYNC_POL = SYNC_ACTIVE_LOW
) (
  input  logic               clk_50,
  input  logic               reset_n,
  input  logic               en,
  output logic               pix_ce,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               line_start,
  output logic               frame_start
);

  raster_state_t state, state_nxt;
  logic   start, advance, load, de_nxt;
  coord_t h_cnt, v_cnt;
  logic   h_wrap, v_wrap, h_active, v_active, h_sync, v_sync;

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (en)  state_nxt = ST_RUN;
      ST_RUN:  if (!en) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The start edge loads outputs for (0,0) without moving the counters.
  always_comb begin
    start   = 1'b0;
    advance = 1'b0;
    if (en) begin
      start   = (state == ST_IDLE);
      advance = (state == ST_RUN) && pix_ce;
    end
  end

  assign load   = start | advance;
  assign de_nxt = h_active & v_active;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk    (clk_50),
    .rst_n  (reset_n),
    .step   (advance),
    .clear  (!en),
    .cnt    (h_cnt),
    .wrap   (h_wrap),
    .active (h_active),
    .sync   (h_sync)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk    (clk_50),
    .rst_n  (reset_n),
    .step   (h_wrap & advance),
    .clear  (!en),
    .cnt    (v_cnt),
    .wrap   (v_wrap),
    .active (v_active),
    .sync   (v_sync)
  );

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      pix_ce      <= 1'b0;
      hsync       <= !SYNC_POL;
      vsync       <= !SYNC_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (!en) begin
      pix_ce      <= 1'b0;
      hsync       <= !SYNC_POL;
      vsync       <= !SYNC_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_ce      <= !pix_ce;
      line_start  <= start | h_wrap;
      frame_start <= start | (h_wrap & v_wrap);
      if (load) begin
        de    <= de_nxt;
        x     <= de_nxt ? h_cnt : '0;
        y     <= de_nxt ? v_cnt : '0;
        hsync <= h_sync ? SYNC_POL : !SYNC_POL;
        vsync <= v_sync ? SYNC_POL : !SYNC_POL;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Scoreboard bench: a raster model derived from elapsed run edges predicts every
// cycle of a full-size 640x480 instance and a tiny-timing instance.
module tb_vga_timing_ctrl;

  logic clk_50 = 1'b0;
  logic reset_n;
  logic en_b, en_s;

  logic       b_pix_ce, b_hsync, b_vsync, b_de, b_ls, b_fs;
  logic [9:0] b_x, b_y;
  logic       s_pix_ce, s_hsync, s_vsync, s_de, s_ls, s_fs;
  logic [9:0] s_x, s_y;

  typedef struct packed {
    logic       pix_ce;
    logic       hsync;
    logic       vsync;
    logic       de;
    logic [9:0] x;
    logic [9:0] y;
    logic       line_start;
    logic       frame_start;
  } obs_t;

  obs_t b_obs, s_obs;
  obs_t q_b[$];
  obs_t q_s[$];
  int   k_b = -1;
  int   k_s = -1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk_50 = ~clk_50;

  vga_timing_ctrl #(
    .H_ACTIVE (640), .H_FP (16), .H_SYNC (96), .H_BP (48),
    .V_ACTIVE (480), .V_FP (10), .V_SYNC (2),  .V_BP (33),
    .SYNC_POL (1'b0)
  ) u_big (
    .clk_50      (clk_50),
    .reset_n     (reset_n),
    .en          (en_b),
    .pix_ce      (b_pix_ce),
    .hsync       (b_hsync),
    .vsync       (b_vsync),
    .de          (b_de),
    .x           (b_x),
    .y           (b_y),
    .line_start  (b_ls),
    .frame_start (b_fs)
  );

  vga_timing_ctrl #(
    .H_ACTIVE (4), .H_FP (1), .H_SYNC (1), .H_BP (1),
    .V_ACTIVE (2), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .SYNC_POL (1'b1)
  ) u_small (
    .clk_50      (clk_50),
    .reset_n     (reset_n),
    .en          (en_s),
    .pix_ce      (s_pix_ce),
    .hsync       (s_hsync),
    .vsync       (s_vsync),
    .de          (s_de),
    .x           (s_x),
    .y           (s_y),
    .line_start  (s_ls),
    .frame_start (s_fs)
  );

  assign b_obs = {b_pix_ce, b_hsync, b_vsync, b_de, b_x, b_y, b_ls, b_fs};
  assign s_obs = {s_pix_ce, s_hsync, s_vsync, s_de, s_x, s_y, s_ls, s_fs};

  // k = edges seen since the run began (-1 idle); pixel advances happen on odd k.
  function automatic obs_t ref_out(int k, int ha, int hf, int hs, int hb,
                                   int va, int vf, int vs, int vb, bit pol);
    obs_t o;
    int ht, vt, adv, n, h, v;
    bit fresh;
    o = '0;
    o.hsync = !pol;
    o.vsync = !pol;
    if (k < 0) return o;
    ht    = ha + hf + hs + hb;
    vt    = va + vf + vs + vb;
    adv   = (k + 1) / 2;
    n     = adv % (ht * vt);
    h     = n % ht;
    v     = n / ht;
    fresh = (k == 0) || (k % 2 == 1);
    o.pix_ce      = (k % 2 == 0);
    o.de          = (h < ha) && (v < va);
    o.x           = o.de ? 10'(h) : 10'd0;
    o.y           = o.de ? 10'(v) : 10'd0;
    o.hsync       = (h >= ha + hf && h < ha + hf + hs) ? pol : !pol;
    o.vsync       = (v >= va + vf && v < va + vf + vs) ? pol : !pol;
    o.line_start  = fresh && (h == 0);
    o.frame_start = fresh && (n == 0);
    return o;
  endfunction

  function automatic obs_t ref_b(int k);
    return ref_out(k, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
  endfunction

  function automatic obs_t ref_s(int k);
    return ref_out(k, 4, 1, 1, 1, 2, 1, 1, 1, 1'b1);
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("pce=%b hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b",
                     o.pix_ce, o.hsync, o.vsync, o.de, o.x, o.y, o.line_start, o.frame_start);
  endfunction

  task automatic check(string name, obs_t act, obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %s required %s", name, $time, fmt(act), fmt(exp));
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk_50);
    #2;
  endtask

  // Model: predicts the response to the inputs sampled on each edge.
  initial begin
    forever begin
      @(posedge clk_50 or negedge reset_n);
      if (!reset_n) begin
        k_b = -1;
        k_s = -1;
        q_b.delete();
        q_s.delete();
      end else begin
        k_b = en_b ? k_b + 1 : -1;
        k_s = en_s ? k_s + 1 : -1;
      end
      q_b.push_back(ref_b(k_b));
      q_s.push_back(ref_s(k_s));
    end
  end

  // Monitor: compares the DUT against the oldest prediction away from the edge.
  initial begin
    obs_t e;
    forever begin
      @(negedge clk_50);
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        check("big_raster", b_obs, e);
      end
      if (q_s.size() > 0) begin
        e = q_s.pop_front();
        check("small_raster", s_obs, e);
      end
    end
  end

  initial begin
    en_b    = 1'b0;
    en_s    = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    check("reset_big", b_obs, ref_b(-1));
    check("reset_small", s_obs, ref_s(-1));
    step(3);
    reset_n = 1'b1;
    step(2);

    en_b = 1'b1;
    en_s = 1'b1;
    step(3300);

    step($urandom_range(1, 1599));
    en_b = 1'b0;
    step(3);
    en_b = 1'b1;
    step(2000);

    for (int i = 0; i < 40; i++) begin
      en_s = 1'b1;
      step($urandom_range(1, 220));
      en_s = 1'b0;
      step($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) begin
        en_b = 1'b0;
        step(1);
        en_b = 1'b1;
      end
    end

    en_s = 1'b1;
    step($urandom_range(20, 90));
    reset_n = 1'b0;
    #1;
    check("async_reset_big", b_obs, ref_b(-1));
    check("async_reset_small", s_obs, ref_s(-1));
    step(2);
    reset_n = 1'b1;
    step(300);

    en_b = 1'b0;
    en_s = 1'b0;
    step(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
